// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the arbitrated ALU: FSM states, ALU select
// encodings and flag bit positions within the {n,c,v,z} flag vector.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] SEL_ADD = 3'd0;  // a + b + cin
  localparam logic [2:0] SEL_SUB = 3'd1;  // a - b - cin
  localparam logic [2:0] SEL_INC = 3'd2;  // a + 1
  localparam logic [2:0] SEL_DEC = 3'd3;  // a - 1
  localparam logic [2:0] SEL_AND = 3'd4;  // a & b
  localparam logic [2:0] SEL_OR  = 3'd5;  // a | b
  localparam logic [2:0] SEL_XOR = 3'd6;  // a ^ b
  localparam logic [2:0] SEL_NOT = 3'd7;  // ~a

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational N-bit ALU with {n,c,v,z} flags. For subtraction forms the
// carry flag is the borrow out; carry in acts as borrow in for SUB.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  input  logic [2:0]   sel_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   flags_o
);

  logic [N:0] wide;
  logic       c;
  logic       v;

  // Operation select, carry/borrow and signed overflow detection.
  always_comb begin
    wide = '0;
    c    = 1'b0;
    v    = 1'b0;
    unique case (sel_i)
      SEL_ADD: begin
        wide = {1'b0, a_i} + {1'b0, b_i} + (N+1)'(cin_i);
        c    = wide[N];
        v    = (a_i[N-1] == b_i[N-1]) && (wide[N-1] != a_i[N-1]);
      end
      SEL_SUB: begin
        wide = {1'b0, a_i} - {1'b0, b_i} - (N+1)'(cin_i);
        c    = wide[N];
        v    = (a_i[N-1] != b_i[N-1]) && (wide[N-1] != a_i[N-1]);
      end
      SEL_INC: begin
        wide = {1'b0, a_i} + (N+1)'(1);
        c    = wide[N];
        v    = !a_i[N-1] && wide[N-1];
      end
      SEL_DEC: begin
        wide = {1'b0, a_i} - (N+1)'(1);
        c    = wide[N];
        v    = a_i[N-1] && !wide[N-1];
      end
      SEL_AND: wide = {1'b0, a_i & b_i};
      SEL_OR:  wide = {1'b0, a_i | b_i};
      SEL_XOR: wide = {1'b0, a_i ^ b_i};
      default: wide = {1'b0, ~a_i};
    endcase
  end

  // Result and flag packing.
  always_comb begin
    result_o         = wide[N-1:0];
    flags_o          = '0;
    flags_o[FLAG_N]  = wide[N-1];
    flags_o[FLAG_C]  = c;
    flags_o[FLAG_V]  = v;
    flags_o[FLAG_Z]  = (wide[N-1:0] == '0);
  end

endmodule

// File: rtl/alu_arbiter_rr_grant.sv
// Round-robin winner selection: one-hot grant to the first asserted request
// found when searching upward (with wrap) from the pointer.
module rr_grant #(
  parameter int REQ = 4
) (
  input  logic [REQ-1:0]         req_i,
  input  logic [$clog2(REQ)-1:0] ptr_i,
  output logic [REQ-1:0]         grant_o
);

  int unsigned idx;
  logic        found;

  // Scan REQ positions starting at the pointer; first hit wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < REQ; k++) begin
      idx = (32'(ptr_i) + k) % REQ;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one shared ALU. Each accepted request runs
// IDLE -> EXEC -> RESP; the response is held until rsp_ready is seen.
// Optional: define ALU_ARB_STATS_EN to add the saturating op_count output.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N   = 10,
  parameter int REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REQ-1:0]         req_valid,
  output logic [REQ-1:0]         req_ready,
  input  logic [REQ*N-1:0]       req_a,
  input  logic [REQ*N-1:0]       req_b,
  input  logic [REQ-1:0]         req_carry_in,
  input  logic [REQ*3-1:0]       req_select,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(REQ)-1:0] rsp_id,
  output logic [N-1:0]           rsp_result,
  output logic [3:0]             rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]            op_count
`endif
);

  localparam int IW = $clog2(REQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [REQ-1:0]  grant;
  logic            hs;

  logic [N-1:0]    win_a, win_b;
  logic            win_cin;
  logic [2:0]      win_sel;
  logic [IW-1:0]   win_id;

  logic [N-1:0]    op_a_q, op_b_q;
  logic            op_cin_q;
  logic [2:0]      op_sel_q;
  logic [IW-1:0]   op_id_q;

  logic [N-1:0]    alu_result;
  logic [3:0]      alu_flags;

  logic [N-1:0]    rsp_result_q;
  logic [3:0]      rsp_flags_q;
  logic [IW-1:0]   rsp_id_q;

  rr_grant #(.REQ(REQ)) u_rr_grant (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Steer the winning requester's fields onto the operation-register inputs.
  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_cin = 1'b0;
    win_sel = '0;
    win_id  = '0;
    for (int unsigned k = 0; k < REQ; k++) begin
      if (grant[k]) begin
        win_a   = req_a[k*N +: N];
        win_b   = req_b[k*N +: N];
        win_cin = req_carry_in[k];
        win_sel = req_select[k*3 +: 3];
        win_id  = IW'(k);
      end
    end
  end

  // Next-state, pointer update and request accept.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    hs        = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst ? '0 : grant;
        if (|grant) begin
          hs      = 1'b1;
          state_d = EXEC;
          ptr_d   = (win_id == IW'(REQ-1)) ? '0 : win_id + IW'(1);
        end
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Operation register: captured on the accept edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cin_q <= 1'b0;
      op_sel_q <= '0;
      op_id_q  <= '0;
    end else if (hs) begin
      op_a_q   <= win_a;
      op_b_q   <= win_b;
      op_cin_q <= win_cin;
      op_sel_q <= win_sel;
      op_id_q  <= win_id;
    end
  end

  alu #(.N(N)) u_alu (
    .a_i      (op_a_q),
    .b_i      (op_b_q),
    .cin_i    (op_cin_q),
    .sel_i    (op_sel_q),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  // Response registers: loaded at the end of EXEC, then held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_id_q     <= '0;
    end else if (state_q == EXEC) begin
      rsp_result_q <= alu_result;
      rsp_flags_q  <= alu_flags;
      rsp_id_q     <= op_id_q;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_id     = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_count_q;

  // Completed-operation counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (state_q == RESP && rsp_ready && op_count_q != '1) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (N=10, REQ=4).
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N   = 10;
  localparam int REQ = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [REQ-1:0]   req_valid;
  logic [REQ-1:0]   req_ready;
  logic [REQ*N-1:0] req_a;
  logic [REQ*N-1:0] req_b;
  logic [REQ-1:0]   req_carry_in;
  logic [REQ*3-1:0] req_select;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [N-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      op_count;
`endif

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.N(N), .REQ(REQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_carry_in (req_carry_in),
    .req_select   (req_select),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_count     (op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated operation on requester idx; inputs scrambled after accept.
  task automatic do_op(input string tag, input int idx, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic cin, input logic [2:0] sel,
                       input logic [N-1:0] er, input logic [3:0] ef);
    logic [REQ-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    @(negedge clk);
    req_a[idx*N +: N]      = a;
    req_b[idx*N +: N]      = b;
    req_carry_in[idx]      = cin;
    req_select[idx*3 +: 3] = sel;
    req_valid              = onehot;
    #1 chk({tag, "_grant"}, 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid              = '0;
    req_a[idx*N +: N]      = ~a;
    req_b[idx*N +: N]      = ~b;
    req_carry_in[idx]      = ~cin;
    req_select[idx*3 +: 3] = ~sel;
    #1 chk({tag, "_exec_vld"}, 32'(rsp_valid), 32'(0));
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'(1));
    chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
    chk({tag, "_res"}, 32'(rsp_result), 32'(er));
    chk({tag, "_flg"}, 32'(rsp_flags), 32'(ef));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk({tag, "_done"}, 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, finish required");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REQ-1:0] exp_g [5];
    int             exp_id [5];
    int             ng;
    int             last;

    rst          = 1'b1;
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    req_carry_in = '0;
    req_select   = '0;
    rsp_ready    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_vld", 32'(rsp_valid), 32'(0));
    chk("rst_id", 32'(rsp_id), 32'(0));
    chk("rst_res", 32'(rsp_result), 32'(0));
    chk("rst_flg", 32'(rsp_flags), 32'(0));
    req_valid = '0;
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("idle_rdy_ignored", 32'(rsp_valid), 32'(0));
    rsp_ready = 1'b0;

    // Basic add on requester 0, subtract-to-zero on requester 2
    do_op("add6p5", 0, 10'd6, 10'd5, 1'b0, SEL_ADD, 10'd11, 4'b0000);
    do_op("sub6m6", 2, 10'd6, 10'd6, 1'b0, SEL_SUB, 10'd0, 4'b0001);

    // Response back-pressure with another request pending
    @(negedge clk);
    req_a[3*N +: N]  = 10'h3FF;
    req_b[3*N +: N]  = 10'h001;
    req_carry_in[3]  = 1'b0;
    req_select[9 +: 3] = SEL_ADD;
    req_valid        = 4'b1000;
    #1 chk("bp_grant", 32'(req_ready), 32'(4'b1000));
    @(negedge clk);
    req_valid = 4'b0010;
    #1 chk("bp_exec_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    #1;
    chk("bp_res", 32'(rsp_result), 32'(0));
    chk("bp_flg", 32'(rsp_flags), 32'(4'b0101));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_vld", 32'(rsp_valid), 32'(1));
      chk("bp_hold_id", 32'(rsp_id), 32'(3));
      chk("bp_hold_res", 32'(rsp_result), 32'(0));
      chk("bp_hold_flg", 32'(rsp_flags), 32'(4'b0101));
      chk("bp_hold_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    #1 chk("bp_ack_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_resume", 32'(req_ready), 32'(4'b0010));
    chk("bp_resume_vld", 32'(rsp_valid), 32'(0));
    // Requester 1 withdraws before being accepted: pointer must not move
    req_valid = '0;
    #1 chk("drop_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    req_valid = 4'b0110;
    #1 chk("drop_ptr_kept", 32'(req_ready), 32'(4'b0010));
    req_valid = '0;

    // ALU coverage: every select, carry/borrow, overflow
    do_op("inc",  1, 10'h1FF, 10'h000, 1'b0, SEL_INC, 10'h200, 4'b1010);
    do_op("dec",  3, 10'h000, 10'h000, 1'b0, SEL_DEC, 10'h3FF, 4'b1100);
    do_op("and",  0, 10'h2AA, 10'h0F0, 1'b0, SEL_AND, 10'h0A0, 4'b0000);
    do_op("or",   2, 10'h200, 10'h001, 1'b0, SEL_OR,  10'h201, 4'b1000);
    do_op("xor",  1, 10'h155, 10'h155, 1'b0, SEL_XOR, 10'h000, 4'b0001);
    do_op("addc", 3, 10'h1FF, 10'h000, 1'b1, SEL_ADD, 10'h200, 4'b1010);
    do_op("subc", 0, 10'd5,   10'd3,   1'b1, SEL_SUB, 10'd1,   4'b0000);
    do_op("subn", 2, 10'd3,   10'd5,   1'b0, SEL_SUB, 10'h3FE, 4'b1100);
    do_op("subv", 1, 10'h200, 10'h001, 1'b0, SEL_SUB, 10'h1FF, 4'b0010);
    do_op("not",  3, 10'h000, 10'h000, 1'b0, SEL_NOT, 10'h3FF, 4'b1000);

    // Reset during EXEC discards the operation and the pointer
    @(negedge clk);
    req_a[2*N +: N]    = 10'd1;
    req_b[2*N +: N]    = 10'd1;
    req_select[6 +: 3] = SEL_ADD;
    req_valid          = 4'b0100;
    #1 chk("rstx_grant", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    #1 chk("rstx_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("rstx_no_rsp", 32'(rsp_valid), 32'(0));
    end
    chk("rstx_res_clr", 32'(rsp_result), 32'(0));
`ifdef ALU_ARB_STATS_EN
    chk("rstx_count", 32'(op_count), 32'(0));
`endif
    req_valid = 4'b1001;
    #1 chk("rstx_next_grant", 32'(req_ready), 32'(4'b0001));

    // All requesters valid, rsp_ready high: rotation and 3-cycle spacing
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{0, 1, 2, 3, 0};
    req_valid = '1;
    rsp_ready = 1'b1;
    ng   = 0;
    last = -10;
    #1;
    for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
      if (ng > 0 && cyc == last + 2) begin
        chk("rr_rsp_vld", 32'(rsp_valid), 32'(1));
        chk("rr_rsp_id", 32'(rsp_id), 32'(exp_id[ng-1]));
      end
      if (req_ready != '0) begin
        chk("rr_grant", 32'(req_ready), 32'(exp_g[ng]));
        if (ng > 0) chk("rr_spacing", 32'(cyc - last), 32'(3));
        last = cyc;
        ng++;
      end
      @(negedge clk);
      #1;
    end
    chk("rr_grant_count", 32'(ng), 32'(5));
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("rr_drain_vld", 32'(rsp_valid), 32'(0));
    chk("rr_drain_ready", 32'(req_ready), 32'(0));
    rsp_ready = 1'b0;

`ifdef ALU_ARB_STATS_EN
    chk("cnt_after_rr", 32'(op_count), 32'(5));
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    #1 release dut.op_count_q;
    #1 chk("cnt_preload", 32'(op_count), 32'(16'hFFFF));
    do_op("cnt_sat_op", 1, 10'd2, 10'd3, 1'b0, SEL_ADD, 10'd5, 4'b0000);
    chk("cnt_sat", 32'(op_count), 32'(16'hFFFF));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
